// File: rtl/lsu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl_pkg
// Description : Shared types for the load/store unit controller: access size,
//               controller state and the latched request bundle, plus the
//               alignment rule used at request accept.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_ctrl_pkg;

    // Access width encoding as presented on req_size
    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_RSV = 2'b11
    } lsu_size_t;

    // Controller sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } lsu_state_t;

    // Request fields captured at accept
    typedef struct packed {
        logic        we;
        lsu_size_t   size;
        logic        is_unsigned;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsu_req_t;

    // True when the size is reserved or the byte address is not naturally aligned
    function automatic logic lsu_misaligned(input lsu_size_t size, input logic [1:0] lo);
        logic r;
        case (size)
            SZ_B:    r = 1'b0;
            SZ_H:    r = lo[0];
            SZ_W:    r = (lo != 2'b00);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_ctrl_lane.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl_lane
// Description : Combinational lane steering. Extracts and sign/zero-extends
//               the addressed byte/half of a memory word for loads, and merges
//               right-justified store data into the addressed lane of an old
//               word for sub-word read-modify-write stores. Little-endian.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_ctrl_lane
    import lsu_ctrl_pkg::*;
(
    input  lsu_size_t   size,
    input  logic        is_unsigned,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_word
);

    logic [4:0]  w_sh;
    logic [31:0] w_shifted;
    logic [31:0] w_mask;
    logic [31:0] w_ins;

    // Lane shift: byte lane addr[1:0]*8, half lane addr[1]*16
    always_comb begin
        w_sh = 5'd0;
        case (size)
            SZ_B:    w_sh = {addr_lo, 3'b000};
            SZ_H:    w_sh = {addr_lo[1], 4'b0000};
            default: w_sh = 5'd0;
        endcase
    end

    assign w_shifted = rword >> w_sh;

    // Load extraction with extension selected by is_unsigned
    always_comb begin
        load_data = rword;
        case (size)
            SZ_B:    load_data = {{24{~is_unsigned & w_shifted[7]}},  w_shifted[7:0]};
            SZ_H:    load_data = {{16{~is_unsigned & w_shifted[15]}}, w_shifted[15:0]};
            default: load_data = rword;
        endcase
    end

    // Byte-enable merge of new store data into the old word
    always_comb begin
        w_mask = 32'hFFFF_FFFF;
        w_ins  = wdata;
        case (size)
            SZ_B: begin
                w_mask = 32'h0000_00FF << w_sh;
                w_ins  = {24'd0, wdata[7:0]} << w_sh;
            end
            SZ_H: begin
                w_mask = 32'h0000_FFFF << w_sh;
                w_ins  = {16'd0, wdata[15:0]} << w_sh;
            end
            default: begin
                w_mask = 32'hFFFF_FFFF;
                w_ins  = wdata;
            end
        endcase
    end

    assign merge_word = (rword & ~w_mask) | (w_ins & w_mask);

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl
// Description : Load/store initiator between EX and the data-memory stage.
//               Accepts one request at a time, issues word-addressed memory
//               accesses (read-modify-write for byte/half stores) and returns
//               extended load data or an error response.
//               Optional build macro LSU_BOUNDS_CHECK_EN adds a range check of
//               the word address against MEM_WORDS.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int MEM_AW    = 10,
    parameter int MEM_WORDS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_rw,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

`ifdef LSU_BOUNDS_CHECK_EN
    localparam logic c_BOUNDS_EN = 1'b1;
`else
    localparam logic c_BOUNDS_EN = 1'b0;
`endif

    localparam logic [31:0] c_MEM_WORDS = 32'(MEM_WORDS);

    lsu_state_t  r_state;
    lsu_req_t    r_req;
    lsu_req_t    w_req;
    logic        w_range_err;
    logic        w_err;
    logic [31:0] w_load_data;
    logic [31:0] w_merge_word;

    assign w_req.we          = req_we;
    assign w_req.size        = lsu_size_t'(req_size);
    assign w_req.is_unsigned = req_unsigned;
    assign w_req.addr        = req_addr;
    assign w_req.wdata       = req_wdata;

    // Out-of-range word address only counts when the range check is built in
    assign w_range_err = c_BOUNDS_EN & ({2'b00, req_addr[31:2]} >= c_MEM_WORDS);
    assign w_err       = lsu_misaligned(w_req.size, req_addr[1:0]) | w_range_err;

    // Address bits above the memory window alias onto it
    generate
        if (MEM_AW < 30) begin : g_alias
            logic w_unused_hi;
            assign w_unused_hi = ^r_req.addr[31:MEM_AW+2];
        end
    endgenerate

    lsu_ctrl_lane u_lane (
        .size        (r_req.size),
        .is_unsigned (r_req.is_unsigned),
        .addr_lo     (r_req.addr[1:0]),
        .rword       (mem_rdata),
        .wdata       (r_req.wdata),
        .load_data   (w_load_data),
        .merge_word  (w_merge_word)
    );

    // Request sequencer: all handshake and memory-side outputs are registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_req      <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            mem_rw     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        r_req     <= w_req;
                        req_ready <= 1'b0;
                        if (w_err) begin
                            // Rejected requests never reach memory
                            r_state    <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else if (req_we && (w_req.size == SZ_W)) begin
                            r_state   <= WR;
                            mem_rw    <= 1'b1;
                            mem_addr  <= req_addr[MEM_AW+1:2];
                            mem_wdata <= req_wdata;
                        end else begin
                            // Loads, and the read half of sub-word stores
                            r_state  <= RD;
                            mem_addr <= req_addr[MEM_AW+1:2];
                        end
                    end
                end
                RD: begin
                    if (r_req.we) begin
                        r_state   <= WR;
                        mem_rw    <= 1'b1;
                        mem_wdata <= w_merge_word;
                    end else begin
                        r_state    <= RESP;
                        mem_addr   <= '0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= w_load_data;
                    end
                end
                WR: begin
                    r_state    <= RESP;
                    mem_rw     <= 1'b0;
                    mem_addr   <= '0;
                    mem_wdata  <= 32'd0;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'd0;
                end
                RESP: begin
                    if (resp_ready) begin
                        r_state    <= IDLE;
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= 32'd0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
